fpu_unpack: RTL and testbench

Unpacks an IEEE-754 half, single or double operand into the FPU's internal wide form: sign, unbiased signed exponent, and a 64-bit mantissa with the integer bit at bit 63. It is the inverse of the FPU normalize stage and sits at the FPU operand input, ahead of the arithmetic units. Subnormal inputs are fully normalized by a multi-cycle shifter, so every finite nonzero result has `out_mant[63]`=1. A valid/ready handshake on each side lets the block stall the issue logic while normalizing.

---
 rtl/fpu_unpack.sv | 214 +++++++++++++++++++++
 tb/tb_fpu_unpack.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_unpack.sv
// IEEE-754 half/single/double unpacker into sign, unbiased exponent and 64-bit mantissa.
// Define FPU_UNPACK_DAZ_EN to flush subnormal inputs to zero instead of normalizing them.
module fpu_unpack #(
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_bits,
  input  logic [1:0]  in_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [15:0] out_exp,
  output logic [63:0] out_mant,
  output logic [2:0]  out_class,
  output logic        out_bad_type
);

  localparam logic [1:0] TYPE_HALF   = 2'd0;
  localparam logic [1:0] TYPE_SINGLE = 2'd1;
  localparam logic [1:0] TYPE_DOUBLE = 2'd2;

  localparam logic [2:0] CLS_ZERO      = 3'd0;
  localparam logic [2:0] CLS_SUBNORMAL = 3'd1;
  localparam logic [2:0] CLS_NORMAL    = 3'd2;
  localparam logic [2:0] CLS_INF       = 3'd3;
  localparam logic [2:0] CLS_QNAN      = 3'd4;
  localparam logic [2:0] CLS_SNAN      = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] EXP_SPECIAL = 16'h7FFF;
  localparam logic [15:0] EXP_STEP    = 16'(SHIFT_STEP);
  localparam int          WIN_LO      = 64 - int'(SHIFT_STEP);

  logic [1:0]  r_state;
  logic        r_sign;
  logic [15:0] r_exp;
  logic [63:0] r_mant;
  logic [2:0]  r_class;
  logic        r_bad_type;

  logic [1:0]  w_state_nxt;
  logic        w_sign_nxt;
  logic [15:0] w_exp_nxt;
  logic [63:0] w_mant_nxt;
  logic [2:0]  w_class_nxt;
  logic        w_bad_nxt;

  logic        w_sign;
  logic [10:0] w_efield;
  logic        w_emax;
  logic [62:0] w_frac;
  logic [15:0] w_bias;
  logic        w_bad;
  logic        w_e_zero;
  logic        w_f_zero;
  logic        w_accept;

  logic        w_dec_sign;
  logic [15:0] w_dec_exp;
  logic [63:0] w_dec_mant;
  logic [2:0]  w_dec_class;
  logic        w_dec_norm;

  logic [4:0]  w_lzc;
  logic        w_win_zero;

  // Fraction is left-aligned into 63 bits so every format shares one decode path.
  always_comb begin
    w_sign   = 1'b0;
    w_efield = '0;
    w_emax   = 1'b0;
    w_frac   = '0;
    w_bias   = '0;
    w_bad    = 1'b0;
    case (in_type)
      TYPE_HALF: begin
        w_sign   = in_bits[15];
        w_efield = {6'b0, in_bits[14:10]};
        w_emax   = &in_bits[14:10];
        w_frac   = {in_bits[9:0], 53'b0};
        w_bias   = 16'd15;
      end
      TYPE_SINGLE: begin
        w_sign   = in_bits[31];
        w_efield = {3'b0, in_bits[30:23]};
        w_emax   = &in_bits[30:23];
        w_frac   = {in_bits[22:0], 40'b0};
        w_bias   = 16'd127;
      end
      TYPE_DOUBLE: begin
        w_sign   = in_bits[63];
        w_efield = in_bits[62:52];
        w_emax   = &in_bits[62:52];
        w_frac   = {in_bits[51:0], 11'b0};
        w_bias   = 16'd1023;
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_e_zero = (w_efield == 11'd0);
  assign w_f_zero = (w_frac == 63'd0);

  always_comb begin
    w_dec_sign  = w_sign;
    w_dec_exp   = '0;
    w_dec_mant  = '0;
    w_dec_class = CLS_ZERO;
    w_dec_norm  = 1'b0;
    if (w_bad) begin
      w_dec_sign = 1'b0;
    end else if (w_emax) begin
      w_dec_exp  = EXP_SPECIAL;
      w_dec_mant = {1'b1, w_frac};
      if (w_f_zero)       w_dec_class = CLS_INF;
      else if (w_frac[62]) w_dec_class = CLS_QNAN;
      else                w_dec_class = CLS_SNAN;
    end else if (!w_e_zero) begin
      w_dec_exp   = {5'b0, w_efield} - w_bias;
      w_dec_mant  = {1'b1, w_frac};
      w_dec_class = CLS_NORMAL;
    end else if (!w_f_zero) begin
`ifdef FPU_UNPACK_DAZ_EN
      w_dec_class = CLS_ZERO;
`else
      w_dec_exp   = 16'd1 - w_bias;
      w_dec_mant  = {1'b0, w_frac};
      w_dec_class = CLS_SUBNORMAL;
      w_dec_norm  = 1'b1;
`endif
    end
  end

  // Leading-zero count within the top SHIFT_STEP bits; higher bits overwrite lower ones.
  always_comb begin
    w_lzc      = '0;
    w_win_zero = 1'b1;
    for (int i = 0; i < int'(SHIFT_STEP); i++) begin
      if (r_mant[WIN_LO + i]) begin
        w_lzc      = 5'(int'(SHIFT_STEP) - 1 - i);
        w_win_zero = 1'b0;
      end
    end
  end

  assign in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_exp_nxt   = r_exp;
    w_mant_nxt  = r_mant;
    w_class_nxt = r_class;
    w_bad_nxt   = r_bad_type;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_sign_nxt  = w_dec_sign;
          w_exp_nxt   = w_dec_exp;
          w_mant_nxt  = w_dec_mant;
          w_class_nxt = w_dec_class;
          w_bad_nxt   = w_bad;
          w_state_nxt = w_dec_norm ? S_NORM : S_DONE;
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NORM: begin
        if (w_win_zero) begin
          w_mant_nxt = r_mant << SHIFT_STEP;
          w_exp_nxt  = r_exp - EXP_STEP;
        end else begin
          w_mant_nxt  = r_mant << w_lzc;
          w_exp_nxt   = r_exp - {11'b0, w_lzc};
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_class    <= CLS_ZERO;
      r_bad_type <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sign     <= w_sign_nxt;
      r_exp      <= w_exp_nxt;
      r_mant     <= w_mant_nxt;
      r_class    <= w_class_nxt;
      r_bad_type <= w_bad_nxt;
    end
  end

  assign out_valid    = (r_state == S_DONE);
  assign out_sign     = r_sign;
  assign out_exp      = r_exp;
  assign out_mant     = r_mant;
  assign out_class    = r_class;
  assign out_bad_type = r_bad_type;

endmodule

// File: tb/tb_fpu_unpack.sv
// Scoreboard bench for fpu_unpack: directed operands, expected results queued at issue.
// Honors FPU_UNPACK_DAZ_EN for the subnormal expectations.
module tb_fpu_unpack;

  localparam int unsigned SS = 8;
  localparam logic [1:0] HALF = 2'd0, SINGLE = 2'd1, DOUBLE = 2'd2, RSVD = 2'd3;
  localparam logic [63:0] ONE = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_bits = '0;
  logic [1:0]  in_type = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [15:0] out_exp;
  logic [63:0] out_mant;
  logic [2:0]  out_class;
  logic        out_bad_type;

  fpu_unpack #(.SHIFT_STEP(SS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bits      (in_bits),
    .in_type      (in_type),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_mant     (out_mant),
    .out_class    (out_class),
    .out_bad_type (out_bad_type)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [15:0] exp;
    logic [63:0] mant;
    logic [2:0]  cls;
    logic        bad;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   pops[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: latency on first sighting of a result, field compare on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out_valid=1 expected no pending result");
          seen = 1'b1;
        end
        if (out_ready) seen = 1'b0;
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          chk("sign", 64'(out_sign), 64'(sb[0].sign));
          chk("exp", 64'(out_exp), 64'(sb[0].exp));
          chk("mant", out_mant, sb[0].mant);
          chk("class", 64'(out_class), 64'(sb[0].cls));
          chk("bad_type", 64'(out_bad_type), 64'(sb[0].bad));
          pops.push_back(cyc);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [63:0] b, input logic [1:0] t, input logic s,
                      input logic [15:0] e, input logic [63:0] m, input logic [2:0] c,
                      input logic bad, input int lat);
    exp_t x;
    int   n;
    in_valid = 1'b1;
    in_bits  = b;
    in_type  = t;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", n);
    end else begin
      x.sign = s;
      x.exp  = e;
      x.mant = m;
      x.cls  = c;
      x.bad  = bad;
      x.lat  = lat;
      x.acc  = cyc + 1;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_sub(input logic [63:0] b, input logic [1:0] t, input logic s,
                          input logic [15:0] e, input int shift);
`ifdef FPU_UNPACK_DAZ_EN
    send(b, t, s, 16'd0, 64'd0, 3'd0, 1'b0, 1);
`else
    send(b, t, s, e, ONE, 3'd1, 1'b0, shift / int'(SS) + 2);
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int np;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_exp", 64'(out_exp), 64'd0);
    chk("rst_mant", out_mant, 64'd0);
    chk("rst_class", 64'(out_class), 64'd0);
    chk("rst_bad", 64'(out_bad_type), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal and special operands, back to back.
    send(64'h3F80_0000, SINGLE, 1'b0, 16'd0, ONE, 3'd2, 1'b0, 1);
    send(64'hDEAD_BEEF_3F80_0000, SINGLE, 1'b0, 16'd0, ONE, 3'd2, 1'b0, 1);
    send(64'hC000_0000_0000_0000, DOUBLE, 1'b1, 16'd1, ONE, 3'd2, 1'b0, 1);
    send(64'h3C00, HALF, 1'b0, 16'd0, ONE, 3'd2, 1'b0, 1);
    send(64'h7BFF, HALF, 1'b0, 16'd15, 64'hFFE0_0000_0000_0000, 3'd2, 1'b0, 1);
    send(64'h0000, HALF, 1'b0, 16'd0, 64'd0, 3'd0, 1'b0, 1);
    send(64'h8000, HALF, 1'b1, 16'd0, 64'd0, 3'd0, 1'b0, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF, RSVD, 1'b0, 16'd0, 64'd0, 3'd0, 1'b1, 1);
    send(64'h7F80_0000, SINGLE, 1'b0, 16'h7FFF, ONE, 3'd3, 1'b0, 1);
    send(64'h7FC0_0000, SINGLE, 1'b0, 16'h7FFF, 64'hC000_0000_0000_0000, 3'd4, 1'b0, 1);
    send(64'h7F80_0001, SINGLE, 1'b0, 16'h7FFF, 64'h8000_0100_0000_0000, 3'd5, 1'b0, 1);
    drain();

    // Smallest double subnormal: 52-bit shift keeps in_ready low for 7 NORM cycles.
    send_sub(64'h1, DOUBLE, 1'b0, -16'sd1074, 52);
`ifndef FPU_UNPACK_DAZ_EN
    n = 0;
    begin : count_busy
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (in_ready) disable count_busy;
        n++;
      end
    end
    chk("norm_busy_cycles", 64'(n), 64'd7);
`endif
    drain();

    send_sub(64'h8001, HALF, 1'b1, -16'sd24, 10);
    send_sub(64'h0040_0000, SINGLE, 1'b0, -16'sd127, 1);
    send_sub(64'h0000_0100, SINGLE, 1'b0, -16'sd141, 15);
    send_sub(64'h0000_1000_0000_0000, DOUBLE, 1'b0, -16'sd1030, 8);
    drain();

    // Back-pressure: result held, next operand not accepted.
    out_ready = 1'b0;
    send(64'h4000_0000, SINGLE, 1'b0, 16'd1, ONE, 3'd2, 1'b0, 1);
    in_valid = 1'b1;
    in_bits  = 64'h4040_0000;
    in_type  = SINGLE;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_mant", out_mant, ONE);
      chk("stall_exp", 64'(out_exp), 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(64'h4040_0000, SINGLE, 1'b0, 16'd1, 64'hC000_0000_0000_0000, 3'd2, 1'b0, 1);
    send(64'h4080_0000, SINGLE, 1'b0, 16'd2, ONE, 3'd2, 1'b0, 1);
    send(64'h3F00_0000, SINGLE, 1'b0, -16'sd1, ONE, 3'd2, 1'b0, 1);
    drain();
    np = pops.size();
    if (np >= 3) begin
      chk("b2b_gap_a", 64'(pops[np-1] - pops[np-2]), 64'd1);
      chk("b2b_gap_b", 64'(pops[np-2] - pops[np-3]), 64'd1);
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_count: got %0d results expected at least 3", np);
    end

    // Reset in the middle of normalization abandons the operand.
    send_sub(64'h1, DOUBLE, 1'b0, -16'sd1074, 52);
    repeat (3) @(posedge clk);
    #1;
`ifndef FPU_UNPACK_DAZ_EN
    chk("mid_norm_in_ready", 64'(in_ready), 64'd0);
`endif
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(64'h3F80_0000, SINGLE, 1'b0, 16'd0, ONE, 3'd2, 1'b0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time limit expected completion");
    $fatal(1, "time limit");
  end

endmodule
